// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - ALU writeback stage: result FIFO, register-file write sequencer, ACC/PSW shadow
//
// Purpose:
//   Buffers ALU result bundles in a small FIFO and retires them in order.
//   Each retiring entry produces one register-file write (A) or, for MUL/DIV,
//   two writes (A then B). On the final write of an entry the accumulator
//   shadow and the PSW flags are updated.
//
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-high reset
//   in_valid        - ALU result bundle valid
//   in_ready        - FIFO has room (count < DEPTH), no same-cycle bypass
//   op_code         - ALU op that produced the bundle
//   des1, des2      - primary / secondary result bytes (MUL/DIV: A and B)
//   des_acc         - accumulator result for single-byte ops
//   desCy/Ac/Ov     - carry, auxiliary carry, overflow out of the ALU
//   rf_wr_valid     - register-file write request
//   rf_wr_ready     - register file accepts the write
//   rf_wr_sel       - write target: 0 = A, 1 = B
//   rf_wr_data      - write data
//   acc             - accumulator shadow
//   psw_cy/ac/ov/p  - PSW flags; psw_p is the parity of acc
//   count           - current FIFO occupancy

module alu_wb_stage #(
  parameter int         DEPTH  = 4,
  parameter logic [3:0] OP_NOP = 4'd0,
  parameter logic [3:0] OP_MUL = 4'd12,
  parameter logic [3:0] OP_DIV = 4'd13
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   op_code,
  input  logic [7:0]                   des1,
  input  logic [7:0]                   des2,
  input  logic [7:0]                   des_acc,
  input  logic                         desCy,
  input  logic                         desAc,
  input  logic                         desOv,
  output logic                         rf_wr_valid,
  input  logic                         rf_wr_ready,
  output logic                         rf_wr_sel,
  output logic [7:0]                   rf_wr_data,
  output logic [7:0]                   acc,
  output logic                         psw_cy,
  output logic                         psw_ac,
  output logic                         psw_ov,
  output logic                         psw_p,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] da;
    logic       cy;
    logic       ac;
    logic       ov;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR_A = 2'd1,
    S_WR_B = 2'd2
  } state_t;

  // State
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  state_t          state_q, state_d;
  logic [7:0]      acc_q, acc_d;
  logic            cy_q, cy_d;
  logic            ac_q, ac_d;
  logic            ov_q, ov_d;
  logic            p_q, p_d;

  // Decoded head / control
  entry_t          head;
  entry_t          in_entry;
  logic            fifo_empty;
  logic            head_nop;
  logic            head_two;
  logic            push;
  logic            pop;
  logic            nop_pop;
  logic            retire;

  assign in_ready   = (count_q < DEPTH_C);
  assign push       = in_valid && in_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign head_nop   = (head.op == OP_NOP);
  assign head_two   = (head.op == OP_MUL) || (head.op == OP_DIV);

  assign in_entry.op = op_code;
  assign in_entry.d1 = des1;
  assign in_entry.d2 = des2;
  assign in_entry.da = des_acc;
  assign in_entry.cy = desCy;
  assign in_entry.ac = desAc;
  assign in_entry.ov = desOv;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. The head is only inspected in IDLE; while writing,
  // the head entry stays put, so sel/data remain stable under backpressure.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !head_nop) begin
          state_d = S_WR_A;
        end
      end
      S_WR_A: begin
        if (rf_wr_ready) begin
          state_d = head_two ? S_WR_B : S_IDLE;
        end
      end
      S_WR_B: begin
        if (rf_wr_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Write data is zero outside the write states so the port is
  // quiet in IDLE and during reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_wr_valid = 1'b0;
    rf_wr_sel   = 1'b0;
    rf_wr_data  = 8'h00;
    nop_pop     = 1'b0;
    retire      = 1'b0;
    case (state_q)
      S_IDLE: begin
        nop_pop = !fifo_empty && head_nop;
      end
      S_WR_A: begin
        rf_wr_valid = 1'b1;
        rf_wr_data  = head_two ? head.d1 : head.da;
        retire      = rf_wr_ready && !head_two;
      end
      S_WR_B: begin
        rf_wr_valid = 1'b1;
        rf_wr_sel   = 1'b1;
        rf_wr_data  = head.d2;
        retire      = rf_wr_ready;
      end
      default: ;
    endcase
  end

  assign pop = retire || nop_pop;

  // ---------------------------------------------------------------------------
  // FIFO and architectural shadow next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    acc_d    = acc_q;
    cy_d     = cy_q;
    ac_d     = ac_q;
    ov_d     = ov_q;
    p_d      = p_q;

    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // The A byte is what was written to A: des1 for MUL/DIV, des_acc otherwise.
    if (retire) begin
      acc_d = head_two ? head.d1 : head.da;
      cy_d  = head.cy;
      ac_d  = head.ac;
      ov_d  = head.ov;
      p_d   = ^acc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= 8'h00;
      cy_q     <= 1'b0;
      ac_q     <= 1'b0;
      ov_q     <= 1'b0;
      p_q      <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      cy_q     <= cy_d;
      ac_q     <= ac_d;
      ov_q     <= ov_d;
      p_q      <= p_d;
    end
  end

  assign acc    = acc_q;
  assign psw_cy = cy_q;
  assign psw_ac = ac_q;
  assign psw_ov = ov_q;
  assign psw_p  = p_q;
  assign count  = count_q;

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Writeback stage directly downstream of the 8-bit ALU.
- Captures each ALU result bundle (op_code, des1, des2, des_acc, desCy, desAc, desOv) into a small FIFO.
- Sequences one or two register-file writes per result through a valid/ready port.
- Maintains the architectural accumulator shadow and PSW flags (CY, AC, OV, P), updated when each result retires.

Parameters:
- DEPTH, 4, number of FIFO entries; power of 2, minimum 2.
- OP_NOP, 4'd0, op_code that performs no write and no flag update.
- OP_MUL, 4'd12, two-byte result op: des1 to A, then des2 to B.
- OP_DIV, 4'd13, two-byte result op: des1 to A, then des2 to B.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  ALU result bundle valid.
- in_ready  output  1  FIFO can accept; equals (count < DEPTH).
- op_code  input  4  ALU operation that produced the bundle.
- des1  input  8  primary result byte.
- des2  input  8  secondary result byte (MUL high byte / DIV remainder).
- des_acc  input  8  accumulator result for single-byte ops.
- desCy  input  1  carry out.
- desAc  input  1  auxiliary carry out.
- desOv  input  1  overflow out.
- rf_wr_valid  output  1  register-file write request.
- rf_wr_ready  input  1  register file accepts write.
- rf_wr_sel  output  1  write target: 0 = A, 1 = B.
- rf_wr_data  output  8  write data.
- acc  output  8  accumulator shadow.
- psw_cy  output  1  carry flag.
- psw_ac  output  1  auxiliary carry flag.
- psw_ov  output  1  overflow flag.
- psw_p  output  1  parity flag; equals XOR-reduce of acc.
- count  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (async assert, takes effect immediately):
  - FIFO emptied, count=0, FSM = IDLE.
  - rf_wr_valid=0, rf_wr_sel=0, rf_wr_data=0.
  - acc=0, psw_cy=psw_ac=psw_ov=psw_p=0.
  - in_ready=1 once rst deasserts.
  - Reset mid-sequence discards all pending entries and any partial MUL/DIV write; no flag or acc update.
- Push:
  - Push occurs on in_valid && in_ready; the entry stores all seven input fields.
  - No bypass: in_ready depends only on count, so a full FIFO refuses a push even when a pop occurs in the same cycle.
  - Simultaneous push and pop leaves count unchanged; pointers wrap modulo DEPTH.
- FSM states: IDLE, WR_A, WR_B. The FIFO head is examined only in IDLE.
  - IDLE, FIFO empty: stay in IDLE.
  - IDLE, head op_code == OP_NOP: pop the head the same cycle; no write; flags and acc unchanged; stay in IDLE.
  - IDLE, any other head op_code: go to WR_A.
  - WR_A drives rf_wr_valid=1, rf_wr_sel=0. rf_wr_data = des1 if op is OP_MUL/OP_DIV, else des_acc.
  - WR_A, rf_wr_ready=0: stay; sel and data held stable.
  - WR_A && rf_wr_ready, two-byte op: go to WR_B.
  - WR_A && rf_wr_ready, single-byte op: retire, go to IDLE.
  - WR_B drives rf_wr_valid=1, rf_wr_sel=1, rf_wr_data=des2; held stable until rf_wr_ready.
  - WR_B && rf_wr_ready: retire, go to IDLE.
- Retire (registered, on the final write handshake edge):
  - Pop the head.
  - acc <= A-byte written.
  - psw_cy/ac/ov <= stored desCy/desAc/desOv.
  - psw_p <= ^(new acc).
- Latency: an entry pushed at edge N with an empty FIFO gives IDLE sees non-empty in cycle N+1, then rf_wr_valid=1 in cycle N+2.
- Throughput:
  - 1 entry per 2 cycles for single-byte ops with rf_wr_ready=1, since IDLE separates entries.
  - 1 per 3 cycles for MUL/DIV.
  - 1 per cycle for NOP.
- rf_wr_valid is never deasserted before its handshake, except by reset.
- Entries retire strictly in push order.

Test Plan:
- Reset: pulse rst mid-cycle -> immediately count=0, rf_wr_valid=0, acc=0x00, all PSW bits 0; in_ready=1 after release.
- Single-byte op: op=4'd1, des_acc=0x5A, desCy=1, desAc=0, desOv=1, rf_wr_ready=1 -> two cycles after push: rf_wr_valid=1, sel=0, data=0x5A. After retire: acc=0x5A, cy=1, ac=0, ov=1, p=0.
- MUL: op=12, des1=0x34, des2=0x12 -> write sel=0 data=0x34, then sel=1 data=0x12 on the next cycle. Afterwards acc=0x34, p=1.
- Backpressure/full: rf_wr_ready=0, push 4 entries -> count=4, in_ready=0, a 5th in_valid is not accepted, rf_wr_data held at head value. Release rf_wr_ready -> all 4 retire in push order.
- NOP interleave: ADD(0x0F, cy=1), NOP, ADD(0xF0, cy=0) -> exactly 2 writes; flags after NOP are still cy=1 with acc=0x0F; final acc=0xF0, cy=0, p=0.
- Reset during WR_B of a DIV with 2 further entries queued -> rf_wr_valid=0 immediately, count=0, acc and PSW cleared; no write for des2.
